// File: rtl/memory_read_merge_pkg.sv
// Shared types and helpers for the read-merge block: FSM states, boolean constants
// and the byte-lane mask used when merging partial TLB reads.
package memory_read_merge_pkg;

  localparam int LINE_BITS_DEFAULT = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    FIRST_WAIT = 2'd1,
    SECOND     = 2'd2
  } state_t;

  function automatic logic [31:0] byte_mask(input logic [2:0] n);
    logic [31:0] mask;
    case (n)
      3'd0:    mask = 32'h0000_0000;
      3'd1:    mask = 32'h0000_00FF;
      3'd2:    mask = 32'h0000_FFFF;
      3'd3:    mask = 32'h00FF_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/memory_read_merge.sv
// Splits one CPU read of 1..4 bytes into one or two TLB reads at the cache-line
// boundary and merges the returned bytes into a single right-justified result.
module memory_read_merge
  import memory_read_merge_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_reset,
  input  logic        read_do,
  output logic        read_done,
  output logic        read_page_fault,
  output logic        read_ac_fault,
  input  logic [1:0]  read_cpl,
  input  logic [31:0] read_address,
  input  logic [2:0]  read_length,
  input  logic        read_lock,
  input  logic        read_rmw,
  output logic [31:0] read_data,
  output logic        tlbread_do,
  input  logic        tlbread_done,
  input  logic        tlbread_page_fault,
  input  logic        tlbread_ac_fault,
  output logic [1:0]  tlbread_cpl,
  output logic [31:0] tlbread_address,
  output logic [2:0]  tlbread_length,
  output logic [2:0]  tlbread_length_full,
  output logic        tlbread_lock,
  output logic        tlbread_rmw,
  input  logic [31:0] tlbread_data
);

  localparam int LINE_BYTES = 2 ** LINE_BITS;

  state_t             state;
  logic [LINE_BITS:0] line_left;
  logic [2:0]         len1;
  logic [2:0]         len2;
  logic [31:0]        addr2;
  logic [2:0]         len1_q;
  logic [2:0]         len2_q;
  logic [31:0]        addr1_q;
  logic [31:0]        addr2_q;
  logic [31:0]        buffer;
  logic               reset_waiting;
  logic               page_fault_q;
  logic               ac_fault_q;
  logic               part_fault;
  logic               abandon;
  logic [31:0]        first_bytes;
  logic [31:0]        merged;

  assign line_left = LINE_BYTES[LINE_BITS:0] - {1'b0, read_address[LINE_BITS-1:0]};
  assign addr2     = {read_address[31:LINE_BITS], {LINE_BITS{1'b0}}} + 32'(LINE_BYTES);

  always_comb begin
    len1 = read_length;
    if (32'(read_length) > 32'(line_left)) begin
      len1 = line_left[2:0];
    end
    len2 = read_length - len1;
  end

  assign tlbread_cpl         = read_cpl;
  assign tlbread_lock        = read_lock;
  assign tlbread_rmw         = read_rmw;
  assign tlbread_length_full = read_length;

  always_comb begin
    tlbread_address = read_address;
    tlbread_length  = len1;
    case (state)
      FIRST_WAIT: begin
        tlbread_address = addr1_q;
        tlbread_length  = len1_q;
      end
      SECOND: begin
        tlbread_address = addr2_q;
        tlbread_length  = len2_q;
      end
      default: begin
        tlbread_address = read_address;
        tlbread_length  = len1;
      end
    endcase
  end

  assign part_fault      = tlbread_page_fault | tlbread_ac_fault;
  assign abandon         = reset_waiting | rd_reset;
  assign first_bytes     = tlbread_data & byte_mask(len1_q);
  assign merged          = buffer | ((tlbread_data & byte_mask(len2_q)) << {len1_q, 3'b000});
  assign read_page_fault = tlbread_page_fault | page_fault_q;
  assign read_ac_fault   = tlbread_ac_fault | ac_fault_q;

  // A flush clears sticky faults even if a fault arrives in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || rd_reset) begin
      page_fault_q <= FALSE;
      ac_fault_q   <= FALSE;
    end else begin
      if (tlbread_page_fault && !reset_waiting) page_fault_q <= TRUE;
      if (tlbread_ac_fault && !reset_waiting)   ac_fault_q   <= TRUE;
    end
  end

  // After a flush the outstanding part is still serviced; its completion is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      tlbread_do    <= FALSE;
      read_done     <= FALSE;
      read_data     <= '0;
      buffer        <= '0;
      reset_waiting <= FALSE;
      len1_q        <= '0;
      len2_q        <= '0;
      addr1_q       <= '0;
      addr2_q       <= '0;
    end else begin
      read_done     <= FALSE;
      reset_waiting <= (state == IDLE) ? FALSE : (reset_waiting | rd_reset);
      case (state)
        IDLE: begin
          len1_q  <= len1;
          len2_q  <= len2;
          addr1_q <= read_address;
          addr2_q <= addr2;
          if (read_do && !rd_reset && !read_page_fault && !read_ac_fault) begin
            tlbread_do <= TRUE;
            state      <= FIRST_WAIT;
          end
        end
        FIRST_WAIT: begin
          if (part_fault) begin
            tlbread_do <= FALSE;
            state      <= IDLE;
          end else if (tlbread_done) begin
            if (abandon) begin
              tlbread_do <= FALSE;
              state      <= IDLE;
            end else if (len2_q != 3'd0) begin
              buffer <= first_bytes;
              state  <= SECOND;
            end else begin
              read_data  <= first_bytes;
              read_done  <= TRUE;
              tlbread_do <= FALSE;
              state      <= IDLE;
            end
          end
        end
        SECOND: begin
          if (part_fault) begin
            tlbread_do <= FALSE;
            state      <= IDLE;
          end else if (tlbread_done) begin
            if (!abandon) begin
              read_data <= merged;
              read_done <= TRUE;
            end
            tlbread_do <= FALSE;
            state      <= IDLE;
          end
        end
        default: begin
          tlbread_do <= FALSE;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_read_merge.sv
// Self-checking bench for memory_read_merge: directed split/wrap/fault/flush reads
// followed by randomized reads, compared every cycle against a byte-level read model.
module tb_memory_read_merge;

  logic        clk;
  logic        rst;
  logic        rd_reset;
  logic        read_do;
  logic        read_done;
  logic        read_page_fault;
  logic        read_ac_fault;
  logic [1:0]  read_cpl;
  logic [31:0] read_address;
  logic [2:0]  read_length;
  logic        read_lock;
  logic        read_rmw;
  logic [31:0] read_data;
  logic        tlbread_do;
  logic        tlbread_done;
  logic        tlbread_page_fault;
  logic        tlbread_ac_fault;
  logic [1:0]  tlbread_cpl;
  logic [31:0] tlbread_address;
  logic [2:0]  tlbread_length;
  logic [2:0]  tlbread_length_full;
  logic        tlbread_lock;
  logic        tlbread_rmw;
  logic [31:0] tlbread_data;

  memory_read_merge dut (
    .clk                 (clk),
    .rst                 (rst),
    .rd_reset            (rd_reset),
    .read_do             (read_do),
    .read_done           (read_done),
    .read_page_fault     (read_page_fault),
    .read_ac_fault       (read_ac_fault),
    .read_cpl            (read_cpl),
    .read_address        (read_address),
    .read_length         (read_length),
    .read_lock           (read_lock),
    .read_rmw            (read_rmw),
    .read_data           (read_data),
    .tlbread_do          (tlbread_do),
    .tlbread_done        (tlbread_done),
    .tlbread_page_fault  (tlbread_page_fault),
    .tlbread_ac_fault    (tlbread_ac_fault),
    .tlbread_cpl         (tlbread_cpl),
    .tlbread_address     (tlbread_address),
    .tlbread_length      (tlbread_length),
    .tlbread_length_full (tlbread_length_full),
    .tlbread_lock        (tlbread_lock),
    .tlbread_rmw         (tlbread_rmw),
    .tlbread_data        (tlbread_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  logic        exp_do;
  logic [31:0] exp_addr;
  logic [2:0]  exp_len;
  logic        exp_done;
  logic [31:0] exp_data;
  logic        exp_pf;
  logic        exp_af;
  logic [31:0] obs_addr2;
  logic [2:0]  obs_len2;

  task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Compared once per cycle, #1 after the rising edge.
  task automatic checkOutput();
    checkValue("tlbread_do", 32'(tlbread_do), 32'(exp_do));
    checkValue("read_done", 32'(read_done), 32'(exp_done));
    checkValue("read_data", read_data, exp_data);
    checkValue("read_page_fault", 32'(read_page_fault), 32'(exp_pf));
    checkValue("read_ac_fault", 32'(read_ac_fault), 32'(exp_af));
    checkValue("length_full", 32'(tlbread_length_full), 32'(read_length));
    checkValue("cpl", 32'(tlbread_cpl), 32'(read_cpl));
    checkValue("lock", 32'(tlbread_lock), 32'(read_lock));
    checkValue("rmw", 32'(tlbread_rmw), 32'(read_rmw));
    if (exp_do) begin
      checkValue("tlbread_address", tlbread_address, exp_addr);
      checkValue("tlbread_length", 32'(tlbread_length), 32'(exp_len));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] len);
    read_address = addr;
    read_length  = len;
    read_cpl     = 2'($urandom);
    read_lock    = 1'($urandom);
    read_rmw     = 1'($urandom);
    read_do      = 1'b1;
  endtask

  task automatic clearTlb();
    tlbread_done       = 1'b0;
    tlbread_page_fault = 1'b0;
    tlbread_ac_fault   = 1'b0;
    tlbread_data       = $urandom;
  endtask

  task automatic idleCycles(input int n);
    read_do = 1'b0;
    repeat (n) step();
  endtask

  // One CPU read; fault_part 1/2 faults that part, flush pulses rd_reset while part 1 is outstanding.
  task automatic doRead(input logic [31:0] addr, input logic [2:0] len,
                        input logic [31:0] d1, input logic [31:0] d2,
                        input int fault_part, input bit fault_ac, input bit flush,
                        output bit faulted);
    int          l1;
    int          l2;
    logic [31:0] a2;
    logic [31:0] merged;
    faulted = 1'b0;
    l1 = 16 - int'(addr[3:0]);
    if (l1 > int'(len)) l1 = int'(len);
    l2 = int'(len) - l1;
    a2 = {addr[31:4], 4'h0} + 32'd16;
    merged = '0;
    for (int i = 0; i < int'(len); i++) begin
      if (i < l1) merged[8*i +: 8] = d1[8*i +: 8];
      else        merged[8*i +: 8] = d2[8*(i-l1) +: 8];
    end

    applyStimulus(addr, len);
    exp_do   = 1'b1;
    exp_addr = addr;
    exp_len  = 3'(l1);
    step();
    if (flush) begin
      rd_reset = 1'b1;
      read_do  = 1'b0;
      step();
      rd_reset = 1'b0;
    end
    repeat ($urandom_range(0, 2)) step();

    tlbread_data = d1;
    tlbread_done = 1'b1;
    if (fault_part == 1) begin
      if (fault_ac) tlbread_ac_fault = 1'b1;
      else          tlbread_page_fault = 1'b1;
      tlbread_done = 1'($urandom);
      exp_do = 1'b0;
      exp_pf = !fault_ac;
      exp_af = fault_ac;
    end else if (flush) begin
      exp_do = 1'b0;
    end else if (l2 > 0) begin
      exp_addr = a2;
      exp_len  = 3'(l2);
    end else begin
      exp_do   = 1'b0;
      exp_done = 1'b1;
      exp_data = merged;
    end
    step();
    clearTlb();
    exp_done = 1'b0;
    if (fault_part == 1) begin
      faulted = !flush;
      if (flush) begin
        exp_pf = 1'b0;
        exp_af = 1'b0;
      end
      return;
    end
    if (flush || l2 == 0) return;

    obs_addr2 = tlbread_address;
    obs_len2  = tlbread_length;
    repeat ($urandom_range(0, 2)) step();
    tlbread_data = d2;
    tlbread_done = 1'b1;
    exp_do = 1'b0;
    if (fault_part == 2) begin
      if (fault_ac) tlbread_ac_fault = 1'b1;
      else          tlbread_page_fault = 1'b1;
      tlbread_done = 1'($urandom);
      exp_pf = !fault_ac;
      exp_af = fault_ac;
    end else begin
      exp_done = 1'b1;
      exp_data = merged;
    end
    step();
    clearTlb();
    exp_done = 1'b0;
    if (fault_part == 2) faulted = 1'b1;
  endtask

  // Sticky fault blocks new reads until rd_reset; rd_reset with read_do in IDLE issues nothing.
  task automatic faultRecovery();
    repeat (2) step();
    rd_reset = 1'b1;
    exp_pf   = 1'b0;
    exp_af   = 1'b0;
    step();
    step();
    rd_reset = 1'b0;
    read_do  = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit          faulted;
    logic [31:0] addr;
    logic [2:0]  len;
    int          r;

    rst = 1'b1;
    rd_reset = 1'b0;
    read_do = 1'b0;
    read_cpl = 2'd0;
    read_address = '0;
    read_length = 3'd1;
    read_lock = 1'b0;
    read_rmw = 1'b0;
    tlbread_done = 1'b0;
    tlbread_page_fault = 1'b0;
    tlbread_ac_fault = 1'b0;
    tlbread_data = '0;
    exp_do = 1'b0;
    exp_addr = '0;
    exp_len = '0;
    exp_done = 1'b0;
    exp_data = '0;
    exp_pf = 1'b0;
    exp_af = 1'b0;
    obs_addr2 = '0;
    obs_len2 = '0;

    repeat (3) step();
    rst = 1'b0;
    step();

    $display("[TB] directed: aligned read");
    doRead(32'h0000_1000, 3'd4, 32'h4433_2211, 32'h0, 0, 1'b0, 1'b0, faulted);
    checkValue("aligned_data", read_data, 32'h4433_2211);
    idleCycles(1);

    $display("[TB] directed: split read");
    doRead(32'h0000_100E, 3'd4, 32'h5A5A_BBAA, 32'h7E7E_DDCC, 0, 1'b0, 1'b0, faulted);
    checkValue("split_addr2", obs_addr2, 32'h0000_1010);
    checkValue("split_len2", 32'(obs_len2), 32'd2);
    checkValue("split_data", read_data, 32'hDDCC_BBAA);

    $display("[TB] directed: back-to-back wrap read");
    doRead(32'hFFFF_FFFF, 3'd2, 32'h1234_56AA, 32'h9876_54BB, 0, 1'b0, 1'b0, faulted);
    checkValue("wrap_addr2", obs_addr2, 32'h0000_0000);
    checkValue("wrap_len2", 32'(obs_len2), 32'd1);
    checkValue("wrap_data", read_data, 32'h0000_BBAA);
    idleCycles(2);

    $display("[TB] directed: second-part page fault");
    doRead(32'h0000_100E, 3'd4, 32'h1111_2222, 32'h3333_4444, 2, 1'b0, 1'b0, faulted);
    checkValue("fault_sticky", 32'(read_page_fault), 32'd1);
    checkValue("fault_data_held", read_data, 32'h0000_BBAA);
    faultRecovery();

    $display("[TB] directed: flush during first part");
    doRead(32'h0000_103E, 3'd4, 32'h5555_6666, 32'h7777_8888, 0, 1'b0, 1'b1, faulted);
    checkValue("flush_data_held", read_data, 32'h0000_BBAA);
    idleCycles(2);

    $display("[TB] randomized reads");
    for (int t = 0; t < 200; t++) begin
      addr = $urandom;
      if ($urandom_range(0, 1) == 1) addr[3:0] = 4'(12 + $urandom_range(0, 3));
      len = 3'($urandom_range(1, 4));
      r = $urandom_range(0, 19);
      doRead(addr, len, $urandom, $urandom, (r == 0) ? 1 : ((r == 1) ? 2 : 0),
             1'($urandom), (r == 2), faulted);
      if (faulted) faultRecovery();
      else if ($urandom_range(0, 1) == 1) idleCycles($urandom_range(1, 2));
    end
    idleCycles(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
